// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: S-box depth, plaintext character bounds and the
// FSM state encoding used by the RC4 pipeline stages.
package rc4_pkg;

  localparam int         S_DEPTH  = 256;
  localparam logic [7:0] ASCII_LO = 8'h61;
  localparam logic [7:0] ASCII_HI = 8'h7A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_INC_I,
    ST_RD_SI_SETUP,
    ST_RD_SI,
    ST_CALC_J,
    ST_ADDR_J,
    ST_RD_SJ_SETUP,
    ST_RD_SJ,
    ST_WR_I,
    ST_WR_J,
    ST_RD_F_SETUP,
    ST_RD_F_WAIT,
    ST_RD_F,
    ST_WR_OUT,
    ST_DONE,
    ST_FAIL
  } rc4_state_e;

endpackage

// File: rtl/rc4_prga_decrypt_if.sv
// Memory/control bus of the PRGA decrypt stage. master = controller plus
// memories, slave = rc4_prga_decrypt.
interface rc4_prga_decrypt_if #(
  parameter int MSG_AW = 5
);
  logic              start;
  logic [7:0]        s_q;
  logic [7:0]        s_addr;
  logic [7:0]        s_data;
  logic              s_wen;
  logic              s_mem_req;
  logic [7:0]        rom_q;
  logic [MSG_AW-1:0] rom_addr;
  logic [MSG_AW-1:0] dec_addr;
  logic [7:0]        dec_data;
  logic              dec_wen;
  logic              done;
  logic              key_valid;

  modport master (
    output start, s_q, rom_q,
    input  s_addr, s_data, s_wen, s_mem_req, rom_addr,
           dec_addr, dec_data, dec_wen, done, key_valid
  );

  modport slave (
    input  start, s_q, rom_q,
    output s_addr, s_data, s_wen, s_mem_req, rom_addr,
           dec_addr, dec_data, dec_wen, done, key_valid
  );
endinterface

// File: rtl/rc4_char_check.sv
// Flags whether a decrypted byte is an acceptable plaintext character
// (lowercase letter or space).
module rc4_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic       o_ok
);
  assign o_ok = ((i_byte >= ASCII_LO) && (i_byte <= ASCII_HI)) || (i_byte == ASCII_SP);
endmodule

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA + XOR decrypt over a shuffled S RAM, 13 cycles per message byte.
// Build with CHAR_CHECK_EN to abort on the first non [a-z ] plaintext byte.
module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = 5
)(
  input  logic                clk,
  input  logic                rst_n,
  rc4_prga_decrypt_if.slave   bus
);

  localparam int                SW     = $clog2(S_DEPTH);
  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

  rc4_state_e        r_state, w_state;
  logic [SW-1:0]     r_i, w_i, r_j, w_j;
  logic [7:0]        r_si, w_si, r_sj, w_sj, r_ks, w_ks, r_enc, w_enc;
  logic [MSG_AW-1:0] r_k, w_k;
  logic [SW-1:0]     r_s_addr, w_s_addr;
  logic [7:0]        r_s_data, w_s_data;
  logic              r_s_wen, w_s_wen, r_mem_req, w_mem_req;
  logic [MSG_AW-1:0] r_rom_addr, w_rom_addr, r_dec_addr, w_dec_addr;
  logic [7:0]        r_dec_data, w_dec_data;
  logic              r_dec_wen, w_dec_wen, r_done, w_done, r_key_valid, w_key_valid;
  logic [7:0]        w_plain;
  logic              w_ok;

  assign w_plain = r_ks ^ r_enc;

`ifdef CHAR_CHECK_EN
  rc4_char_check u_char_check (.i_byte(w_plain), .o_ok(w_ok));
`else
  assign w_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state;
  end

  always_comb begin
    w_state     = r_state;
    w_i         = r_i;
    w_j         = r_j;
    w_k         = r_k;
    w_si        = r_si;
    w_sj        = r_sj;
    w_ks        = r_ks;
    w_enc       = r_enc;
    w_s_addr    = r_s_addr;
    w_s_data    = r_s_data;
    w_s_wen     = 1'b0;
    w_mem_req   = r_mem_req;
    w_rom_addr  = r_rom_addr;
    w_dec_addr  = r_dec_addr;
    w_dec_data  = r_dec_data;
    w_dec_wen   = 1'b0;
    w_done      = r_done;
    w_key_valid = r_key_valid;
    unique case (r_state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (bus.start) begin
          w_state     = ST_INC_I;
          w_i         = '0;
          w_j         = '0;
          w_k         = '0;
          w_mem_req   = 1'b1;
          w_done      = 1'b0;
          w_key_valid = 1'b0;
        end
      end
      ST_INC_I: begin
        w_i      = r_i + 8'd1;
        w_s_addr = r_i + 8'd1;
        w_state  = ST_RD_SI_SETUP;
      end
      ST_RD_SI_SETUP: w_state = ST_RD_SI;
      ST_RD_SI: begin
        w_si    = bus.s_q;
        w_state = ST_CALC_J;
      end
      ST_CALC_J: begin
        w_j     = r_j + r_si;
        w_state = ST_ADDR_J;
      end
      ST_ADDR_J: begin
        w_s_addr = r_j;
        w_state  = ST_RD_SJ_SETUP;
      end
      ST_RD_SJ_SETUP: w_state = ST_RD_SJ;
      ST_RD_SJ: begin
        w_sj    = bus.s_q;
        w_state = ST_WR_I;
      end
      // When i==j both writes carry the same value, so the swap is a no-op.
      ST_WR_I: begin
        w_s_addr = r_i;
        w_s_data = r_sj;
        w_s_wen  = 1'b1;
        w_state  = ST_WR_J;
      end
      ST_WR_J: begin
        w_s_addr = r_j;
        w_s_data = r_si;
        w_s_wen  = 1'b1;
        w_state  = ST_RD_F_SETUP;
      end
      ST_RD_F_SETUP: begin
        w_s_addr   = r_si + r_sj;
        w_rom_addr = r_k;
        w_state    = ST_RD_F_WAIT;
      end
      ST_RD_F_WAIT: w_state = ST_RD_F;
      ST_RD_F: begin
        w_ks    = bus.s_q;
        w_enc   = bus.rom_q;
        w_state = ST_WR_OUT;
      end
      // The write strobe lands in the following cycle, which doubles as the
      // per-byte bookkeeping step so the loop stays at 13 cycles.
      ST_WR_OUT: begin
        w_dec_addr = r_k;
        w_dec_data = w_plain;
        w_dec_wen  = 1'b1;
        if (!w_ok) begin
          w_state     = ST_FAIL;
          w_done      = 1'b1;
          w_key_valid = 1'b0;
          w_mem_req   = 1'b0;
        end else if (r_k == K_LAST) begin
          w_state     = ST_DONE;
          w_done      = 1'b1;
          w_key_valid = 1'b1;
          w_mem_req   = 1'b0;
        end else begin
          w_k     = r_k + 1'b1;
          w_state = ST_INC_I;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_si        <= '0;
      r_sj        <= '0;
      r_ks        <= '0;
      r_enc       <= '0;
      r_s_addr    <= '0;
      r_s_data    <= '0;
      r_s_wen     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_rom_addr  <= '0;
      r_dec_addr  <= '0;
      r_dec_data  <= '0;
      r_dec_wen   <= 1'b0;
      r_done      <= 1'b0;
      r_key_valid <= 1'b0;
    end else begin
      r_i         <= w_i;
      r_j         <= w_j;
      r_k         <= w_k;
      r_si        <= w_si;
      r_sj        <= w_sj;
      r_ks        <= w_ks;
      r_enc       <= w_enc;
      r_s_addr    <= w_s_addr;
      r_s_data    <= w_s_data;
      r_s_wen     <= w_s_wen;
      r_mem_req   <= w_mem_req;
      r_rom_addr  <= w_rom_addr;
      r_dec_addr  <= w_dec_addr;
      r_dec_data  <= w_dec_data;
      r_dec_wen   <= w_dec_wen;
      r_done      <= w_done;
      r_key_valid <= w_key_valid;
    end
  end

  assign bus.s_addr    = r_s_addr;
  assign bus.s_data    = r_s_data;
  assign bus.s_wen     = r_s_wen;
  assign bus.s_mem_req = r_mem_req;
  assign bus.rom_addr  = r_rom_addr;
  assign bus.dec_addr  = r_dec_addr;
  assign bus.dec_data  = r_dec_data;
  assign bus.dec_wen   = r_dec_wen;
  assign bus.done      = r_done;
  assign bus.key_valid = r_key_valid;

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt (MSG_LEN=256): plain RC4 reference model,
// randomized S permutations/messages, bus rules checked every cycle.
module tb_rc4_prga_decrypt;

  localparam int L = 256;
`ifdef CHAR_CHECK_EN
  localparam bit CC = 1'b1;
`else
  localparam bit CC = 1'b0;
`endif

  logic clk, rst_n, ld_en;
  rc4_prga_decrypt_if #(.MSG_AW(8)) bus();

  rc4_prga_decrypt #(.MSG_LEN(L), .MSG_AW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] smem [256];
  logic [7:0] img_s [256];
  logic [7:0] rom [256];
  logic [7:0] dec [256];
  logic [7:0] exp_S [256];
  logic [7:0] exp_plain [256];
  logic [7:0] ks_arr [256];
  int exp_n, wr_cnt, s_run, n_tot, n_pass;
  logic exp_kv, active, prev_dwen;
  logic [23:0] snap;

  // Synchronous memories: q is the word at the address seen on the previous edge.
  always @(posedge clk) begin
    if (ld_en) smem <= img_s;
    else if (bus.s_wen) smem[bus.s_addr] <= bus.s_data;
    bus.s_q   <= smem[bus.s_addr];
    bus.rom_q <= rom[bus.rom_addr];
    if (bus.dec_wen) dec[bus.dec_addr] <= bus.dec_data;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic bit bad_char(input logic [7:0] p);
    return !(((p >= 8'h61) && (p <= 8'h7A)) || (p == 8'h20));
  endfunction

  // Textbook RC4 PRGA on a copy of img_s; with use_cc it stops at the first bad byte.
  task automatic model(input bit use_cc);
    logic [7:0] s [256];
    logic [7:0] i, j, t, x;
    s = img_s; i = 0; j = 0;
    exp_n = L; exp_kv = 1'b1;
    for (int k = 0; k < L; k++) begin
      i = i + 1;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      x = s[i] + s[j];
      ks_arr[k]    = s[x];
      exp_plain[k] = rom[k] ^ ks_arr[k];
      if (use_cc && CC && bad_char(exp_plain[k])) begin
        exp_n = k + 1; exp_kv = 1'b0;
        break;
      end
    end
    exp_S = s;
  endtask

  task automatic perm();
    logic [7:0] t;
    int r;
    for (int n = 0; n < 256; n++) img_s[n] = n[7:0];
    for (int n = 255; n > 0; n--) begin
      r = $urandom_range(0, n);
      t = img_s[n]; img_s[n] = img_s[r]; img_s[r] = t;
    end
  endtask

  task automatic rand_rom();
    for (int n = 0; n < 256; n++) rom[n] = 8'($urandom);
  endtask

  // Encrypt a random lowercase/space message under the keystream of img_s.
  task automatic mk_good();
    int r;
    model(1'b0);
    for (int k = 0; k < L; k++) begin
      r = $urandom_range(0, 26);
      rom[k] = ((r == 26) ? 8'h20 : 8'h61 + 8'(r)) ^ ks_arr[k];
    end
    model(1'b1);
  endtask

  task automatic load();
    ld_en = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic from_smem();
    for (int n = 0; n < 256; n++) img_s[n] = smem[n];
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (rst_n) begin
      if (bus.s_wen || bus.dec_wen) chk("wen_excl", bus.s_wen & bus.dec_wen, 0);
      s_run = bus.s_wen ? s_run + 1 : 0;
      if (bus.s_wen) chk("s_wen_run", s_run <= 2, 1);
      if (bus.dec_wen) begin
        chk("dec_pulse", prev_dwen, 0);
        chk("dec_extra", wr_cnt < exp_n, 1);
        chk("dec_addr", bus.dec_addr, wr_cnt % 256);
        chk("dec_data", bus.dec_data, exp_plain[wr_cnt % 256]);
        if (wr_cnt == 1) snap = {smem[1], smem[2], smem[3]};
        wr_cnt++;
      end
      chk("mem_req", bus.s_mem_req, active && !bus.done);
    end
    prev_dwen = bus.dec_wen;
  endtask

  task automatic run(input int poke_at);
    int n, errs;
    wr_cnt = 0; s_run = 0;
    bus.start = 1'b1; active = 1'b1;
    step(); n = 1;
    bus.start = 1'b0;
    chk("done_drop", bus.done, 0);
    while (!bus.done && n < 13 * L + 20) begin
      if (n == poke_at) bus.start = 1'b1;
      step(); n++;
      bus.start = 1'b0;
    end
    chk("latency", n, 13 * exp_n + 1);
    chk("key_valid", bus.key_valid, exp_kv);
    chk("wr_count", wr_cnt, exp_n);
    chk("mem_req_end", bus.s_mem_req, 0);
    repeat (3) step();
    errs = 0;
    for (int a = 0; a < 256; a++) if (smem[a] !== exp_S[a]) errs++;
    chk("s_final", errs, 0);
  endtask

  initial begin
    n_tot = 0; n_pass = 0; wr_cnt = 0; s_run = 0; exp_n = 0;
    active = 1'b0; prev_dwen = 1'b0; snap = '0;
    rst_n = 1'b0; bus.start = 1'b0; ld_en = 1'b0;
    for (int n = 0; n < 256; n++) begin img_s[n] = n[7:0]; rom[n] = 8'h0; end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.s_addr, bus.s_data, bus.s_wen, bus.s_mem_req, bus.rom_addr,
        bus.dec_addr, bus.dec_data, bus.dec_wen, bus.done, bus.key_valid}, 64'h0);
    rst_n = 1'b1;
    step();

    // 1: identity S, first two bytes hand-computed (i==j on byte 0)
    for (int n = 0; n < 256; n++) img_s[n] = n[7:0];
    rand_rom(); rom[0] = 8'h63; rom[1] = 8'h66;
    model(1'b1);
    chk("model_ks0", ks_arr[0], 8'h02);
    chk("model_ks1", ks_arr[1], 8'h05);
    chk("model_p0", exp_plain[0], 8'h61);
    chk("model_p1", exp_plain[1], 8'h63);
    load(); run(0);
    chk("dec0", dec[0], 8'h61);
    chk("dec1", dec[1], 8'h63);
    chk("s123_after_byte1", snap, 24'h010302);

    // 2: first plaintext byte 0x00
    for (int n = 0; n < 256; n++) img_s[n] = n[7:0];
    rand_rom(); rom[0] = 8'h02;
    model(1'b1);
    chk("model_p0_zero", exp_plain[0], 8'h00);
    chk("model_fail_len", exp_n, CC ? 1 : L);
    load(); run(0);
    chk("done_after_bad", bus.done, 1);
    chk("kv_after_bad", bus.key_valid, !CC);

    // 3: reset during RD_SJ of byte 5, then a clean run
    perm(); mk_good(); load();
    wr_cnt = 0; s_run = 0;
    bus.start = 1'b1; active = 1'b1; step(); bus.start = 1'b0;
    for (int n = 2; n <= 72; n++) step();
    rst_n = 1'b0; active = 1'b0;
    #1;
    chk("rst_mid_outputs", {bus.s_addr, bus.s_data, bus.s_wen, bus.s_mem_req, bus.rom_addr,
        bus.dec_addr, bus.dec_data, bus.dec_wen, bus.done, bus.key_valid}, 64'h0);
    chk("writes_before_rst", wr_cnt, 5);
    repeat (4) begin
      @(posedge clk); #1;
      chk("rst_hold", {bus.s_wen, bus.dec_wen, bus.s_mem_req}, 0);
    end
    rst_n = 1'b1;
    step(); step();
    from_smem(); mk_good(); run(0);

    // 4: S[1]=255, full 256-byte run exercising i wrap
    perm();
    for (int n = 0; n < 256; n++) if (img_s[n] == 8'hFF) begin img_s[n] = img_s[1]; img_s[1] = 8'hFF; end
    mk_good(); load(); run(0);

    // 5: start while busy (byte 3) is ignored; then restart from DONE
    perm(); mk_good(); load(); run(1 + 13 * 3 + 2);
    from_smem(); mk_good(); run(0);

    // 6: random ciphertext
    perm(); rand_rom(); model(1'b1); load(); run(0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
